// File: rtl/tremolo_modulator.sv
// Tremolo stage: applies a depth-scaled gain derived from the signed LFO word to audio samples.
// Optional build macro TREMOLO_ROUND_EN selects round-half-up instead of floor on the final shift.
module tremolo_modulator #(
    parameter int DW      = 16,
    parameter int LW      = 16,
    parameter int DEPTH_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [DEPTH_W-1:0] i_depth,
    input  logic [LW-1:0]      i_lfo,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DW-1:0]      i_sample,
    output logic [DW-1:0]      o_sample,
    output logic               o_valid
);

    localparam int GW = 16;
    localparam int AW = GW + DEPTH_W;
    localparam int PW = DW + GW + 1;
    localparam logic [PW-1:0] ROUND_HALF = PW'(1) << (GW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAIN,
        S_MUL,
        S_OUT
    } state_t;

    state_t               r_state;
    logic [DW-1:0]        r_sample;
    logic [LW-1:0]        r_lfo;
    logic [DEPTH_W-1:0]   r_depth;
    logic                 r_start;
    logic [GW-1:0]        r_gain;

    logic [GW-1:0]        w_g;
    logic [AW-1:0]        w_atten;
    logic [GW-1:0]        w_gain;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_prod_r;
    logic                 w_ovf;
    logic [DW-1:0]        w_res;
    logic                 w_unused_bits;

    // Offset-binary view of the LFO: flipping the sign bit adds 32768.
    assign w_g     = r_lfo[LW-1 -: GW] ^ {1'b1, {(GW-1){1'b0}}};
    assign w_atten = {{DEPTH_W{1'b0}}, ~w_g} * {{GW{1'b0}}, r_depth};
    assign w_gain  = ~w_atten[AW-1:DEPTH_W];

    assign w_prod = $signed({{(GW+1){r_sample[DW-1]}}, r_sample})
                  * $signed({{(DW+1){1'b0}}, r_gain});

`ifdef TREMOLO_ROUND_EN
    assign w_prod_r = w_prod + $signed(ROUND_HALF);
`else
    assign w_prod_r = w_prod;
`endif

    // Guard clamp: the top two product bits disagree only if the result would not fit DW.
    assign w_ovf = w_prod_r[PW-1] ^ w_prod_r[PW-2];
    assign w_res = !w_ovf         ? w_prod_r[PW-2:GW] :
                   w_prod_r[PW-1] ? {1'b1, {(DW-1){1'b0}}} :
                                    {1'b0, {(DW-1){1'b1}}};

    assign w_unused_bits = &{1'b0, w_atten[DEPTH_W-1:0], w_prod_r[GW-1:0]};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_lfo    <= '0;
            r_depth  <= '0;
            r_start  <= 1'b0;
            r_gain   <= '0;
            o_sample <= '0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_valid <= 1'b0;
                    if (i_valid) begin
                        r_sample <= i_sample;
                        r_lfo    <= i_lfo;
                        r_depth  <= i_depth;
                        r_start  <= i_start;
                        o_ready  <= 1'b0;
                        r_state  <= S_GAIN;
                    end
                end
                S_GAIN: begin
                    r_gain  <= w_gain;
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    o_sample <= r_start ? w_res : r_sample;
                    o_valid  <= 1'b1;
                    r_state  <= S_OUT;
                end
                S_OUT: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tremolo_modulator.sv
// Randomized and directed bench for tremolo_modulator against an arithmetic reference model.
module tb_tremolo_modulator;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_depth = '0;
    logic [15:0] i_lfo = '0;
    logic        i_valid = 1'b0;
    logic [15:0] i_sample = '0;
    logic        o_ready;
    logic [15:0] o_sample;
    logic        o_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int n_ovalid = 0;
    int since    = 100;
    longint last_out = 0;
    longint q[$];

    always #5 clk = ~clk;

    tremolo_modulator dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_depth  (i_depth),
        .i_lfo    (i_lfo),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sample (i_sample),
        .o_sample (o_sample),
        .o_valid  (o_valid)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: gain = 65535 - (65535 - (lfo+32768)) * depth / 8, out = floor(sample*gain / 65536).
    function automatic longint model(input longint s, input longint l, input longint d, input bit st);
        longint g, a, gain, p, r;
        if (!st) return s;
        g    = l + 32768;
        a    = ((65535 - g) * d) / 8;
        gain = 65535 - a;
        p    = s * gain;
`ifdef TREMOLO_ROUND_EN
        p    = p + 32768;
`endif
        r    = p >>> 16;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    always @(negedge clk) begin
        if (i_rst) begin
            q.delete();
            since    = 100;
            last_out = 0;
        end else begin
            if (since < 100) since++;
            check("o_valid", longint'(o_valid), longint'(since == 3));
            check("o_ready", longint'(o_ready), longint'(since >= 4));
            if (o_valid) n_ovalid++;
            if (since == 3) begin
                if (q.size() > 0) begin
                    last_out = q.pop_front();
                    $display("txn %0d: out=%0d expected=%0d", n_ovalid, $signed(o_sample), last_out);
                end else begin
                    check("sb_underflow", longint'(q.size()), 1);
                end
            end
            check("o_sample", longint'($signed(o_sample)), last_out);
            if (i_valid && o_ready) begin
                q.push_back(model(longint'($signed(i_sample)), longint'($signed(i_lfo)),
                                  longint'(i_depth), i_start));
                since = 0;
                n_accept++;
            end
        end
    end

    task automatic drive(input logic [15:0] s, input logic [15:0] l, input logic [2:0] d,
                         input logic st, input logic v);
        i_sample = s;
        i_lfo    = l;
        i_depth  = d;
        i_start  = st;
        i_valid  = v;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && !o_ready; n++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_expect(input string tag, input logic [15:0] s, input logic [15:0] l,
                               input logic [2:0] d, input logic st, input longint exp);
        int lat;
        wait_idle();
        drive(s, l, d, st, 1'b1);
        @(posedge clk); #1;
        drive($urandom, $urandom, $urandom, $urandom, 1'b0);
        lat = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 2);
        check(tag, longint'($signed(o_sample)), exp);
    endtask

    initial begin
        int acc0, val0;
        logic [15:0] l;

        repeat (2) @(posedge clk);
        #1;
        check("rst_sample", longint'(o_sample), 0);
        check("rst_valid", longint'(o_valid), 0);
        check("rst_ready", longint'(o_ready), 1);
        i_rst = 1'b0;
        @(posedge clk); #1;

        send_expect("bypass", 16'h1234, 16'h7000, 3'd5, 1'b0, 64'sh1234);
`ifdef TREMOLO_ROUND_EN
        send_expect("zero_depth", 16'h4000, 16'h0000, 3'd0, 1'b1, 64'sh4000);
`else
        send_expect("zero_depth", 16'h4000, 16'h0000, 3'd0, 1'b1, 64'sh3FFF);
`endif
        send_expect("full_trough", 16'h4000, 16'h8000, 3'd7, 1'b1, 64'sh0800);
        send_expect("mid_neg", 16'hC000, 16'h0000, 3'd4, 1'b1, -64'sd12288);

        // Continuous valid for 8 cycles: only every fourth cycle may be accepted.
        wait_idle();
        acc0 = n_accept;
        val0 = n_ovalid;
        for (int i = 0; i < 8; i++) begin
            drive($urandom, $urandom, $urandom, 1'b1, 1'b1);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("hs_accepts", n_accept - acc0, 2);
        check("hs_pulses", n_ovalid - val0, 2);

        // Reset while the sample sits in S_MUL: nothing may come out for it.
        wait_idle();
        drive(16'h3000, 16'h1000, 3'd3, 1'b1, 1'b1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #2;
        val0 = n_ovalid;
        i_rst = 1'b1;
        #1;
        check("abort_valid", longint'(o_valid), 0);
        check("abort_ready", longint'(o_ready), 1);
        check("abort_sample", longint'(o_sample), 0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_idle", longint'(o_ready), 1);
        check("abort_no_pulse", n_ovalid - val0, 0);

        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(3))
                0: l = 16'h8000;
                1: l = 16'h7FFF;
                default: l = 16'($urandom);
            endcase
            drive(($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom), l,
                  3'($urandom), ($urandom_range(4) != 0), ($urandom_range(2) != 0));
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("sb_drain", longint'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
